// File: rtl/p405s_dtlb_missctl_pkg.sv
// rtl/p405s_dtlb_missctl_pkg.sv - shared types and default sizes for the data-side shadow TLB miss controller
package p405s_dtlb_missctl_pkg;

    localparam int NUM_ENT_DEF = 4;
    localparam int EA_W_DEF    = 22;
    localparam int SIZE_W_DEF  = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_FILL = 2'd3
    } state_t;

endpackage

// File: rtl/p405s_dtlb_missctl_if.sv
// rtl/p405s_dtlb_missctl_if.sv - core data-side and UTLB handshake bundle for the DTLB miss controller
interface p405s_dtlb_missctl_if
    import p405s_dtlb_missctl_pkg::*;
#(
    parameter int NUM_ENT = NUM_ENT_DEF,
    parameter int EA_W    = EA_W_DEF,
    parameter int SIZE_W  = SIZE_W_DEF
);
    localparam int IDX_W = $clog2(NUM_ENT);

    logic                ds_req_valid;
    logic                msr_dr;
    logic [EA_W-1:0]     exe_ds_ea;
    logic [NUM_ENT-1:0]  ent_hit;
    logic                ds_flush;
    logic                invalidate_all;
    logic                utlb_gnt;
    logic                utlb_rsp_valid;
    logic                utlb_hit;
    logic [EA_W-1:0]     utlb_rpn;
    logic [SIZE_W-1:0]   utlb_size;

    logic                ds_hold;
    logic                dtlb_hit;
    logic [IDX_W-1:0]    hit_idx;
    logic                multi_hit;
    logic                utlb_req;
    logic [EA_W-1:0]     utlb_req_ea;
    logic [NUM_ENT-1:0]  ent_we;
    logic [NUM_ENT-1:0]  ent_valid;
    logic [EA_W-1:0]     fill_rpn;
    logic [SIZE_W-1:0]   fill_size;
    logic                dtlb_miss_exc;

    modport master (
        output ds_req_valid, msr_dr, exe_ds_ea, ent_hit, ds_flush, invalidate_all,
        output utlb_gnt, utlb_rsp_valid, utlb_hit, utlb_rpn, utlb_size,
        input  ds_hold, dtlb_hit, hit_idx, multi_hit, utlb_req, utlb_req_ea,
        input  ent_we, ent_valid, fill_rpn, fill_size, dtlb_miss_exc
    );

    modport slave (
        input  ds_req_valid, msr_dr, exe_ds_ea, ent_hit, ds_flush, invalidate_all,
        input  utlb_gnt, utlb_rsp_valid, utlb_hit, utlb_rpn, utlb_size,
        output ds_hold, dtlb_hit, hit_idx, multi_hit, utlb_req, utlb_req_ea,
        output ent_we, ent_valid, fill_rpn, fill_size, dtlb_miss_exc
    );

endinterface

// File: rtl/p405s_dtlb_missctl_victim_sel.sv
// rtl/p405s_dtlb_missctl_victim_sel.sv - victim slot choice: lowest invalid entry, else round-robin pointer
module p405s_dtlb_missctl_victim_sel
    import p405s_dtlb_missctl_pkg::*;
#(
    parameter int NUM_ENT = NUM_ENT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_ENT-1:0] valid,
    input  logic               advance,
    output logic [NUM_ENT-1:0] victim
);
    localparam int IDX_W = $clog2(NUM_ENT);

    logic [IDX_W-1:0] ptr;
    logic             all_valid;

    assign all_valid = &valid;

    always_comb begin
        victim = NUM_ENT'(1) << ptr;
        for (int i = NUM_ENT - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                victim = NUM_ENT'(1) << i;
            end
        end
    end

    // Pointer only moves when an already-valid slot is overwritten; wraps naturally (NUM_ENT is a power of 2).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && all_valid) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/p405s_dtlb_missctl.sv
// rtl/p405s_dtlb_missctl.sv - data-side shadow TLB miss/fill controller: hit qualify, stall, UTLB fetch, victim fill
module p405s_dtlb_missctl
    import p405s_dtlb_missctl_pkg::*;
#(
    parameter int NUM_ENT = NUM_ENT_DEF,
    parameter int EA_W    = EA_W_DEF,
    parameter int SIZE_W  = SIZE_W_DEF
) (
    input logic                 clk,
    input logic                 rst_n,
    p405s_dtlb_missctl_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_ENT);

    state_t             state;
    logic [NUM_ENT-1:0] valid_q;
    logic [NUM_ENT-1:0] victim;
    logic [NUM_ENT-1:0] qh;
    logic [EA_W-1:0]    req_ea_q;
    logic [EA_W-1:0]    fill_rpn_q;
    logic [SIZE_W-1:0]  fill_size_q;
    logic               exc_q;
    logic               squash_q;
    logic               access;
    logic               any_hit;
    logic               in_flight;
    logic               squash_now;
    logic               fill_commit;
    logic [IDX_W-1:0]   low_idx;
    logic [IDX_W:0]     hit_cnt;

    assign qh          = bus.ent_hit & valid_q;
    assign any_hit     = |qh;
    assign access      = bus.ds_req_valid & bus.msr_dr & ~bus.ds_flush;
    assign in_flight   = (state == ST_REQ) || (state == ST_WAIT);
    // A squash raised in the same cycle as the response must still cancel the fill.
    assign squash_now  = squash_q | (in_flight & (bus.ds_flush | bus.invalidate_all));
    assign fill_commit = (state == ST_FILL) & ~bus.invalidate_all;

    always_comb begin
        low_idx = '0;
        hit_cnt = '0;
        for (int i = NUM_ENT - 1; i >= 0; i--) begin
            if (qh[i]) begin
                low_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_ENT; i++) begin
            hit_cnt = hit_cnt + (IDX_W + 1)'(qh[i]);
        end
    end

    p405s_dtlb_missctl_victim_sel #(
        .NUM_ENT (NUM_ENT)
    ) u_victim_sel (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (valid_q),
        .advance (fill_commit),
        .victim  (victim)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            valid_q     <= '0;
            req_ea_q    <= '0;
            fill_rpn_q  <= '0;
            fill_size_q <= '0;
            exc_q       <= 1'b0;
            squash_q    <= 1'b0;
        end else begin
            exc_q <= 1'b0;
            if (bus.invalidate_all) begin
                valid_q <= '0;
            end else if (state == ST_FILL) begin
                valid_q <= valid_q | victim;
            end
            case (state)
                ST_IDLE: begin
                    squash_q <= 1'b0;
                    if (access && !any_hit) begin
                        req_ea_q <= bus.exe_ds_ea;
                        state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    squash_q <= squash_now;
                    if (bus.utlb_gnt) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    squash_q <= squash_now;
                    if (bus.utlb_rsp_valid) begin
                        if (squash_now) begin
                            squash_q <= 1'b0;
                            state    <= ST_IDLE;
                        end else if (bus.utlb_hit) begin
                            fill_rpn_q  <= bus.utlb_rpn;
                            fill_size_q <= bus.utlb_size;
                            state       <= ST_FILL;
                        end else begin
                            exc_q <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_FILL: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.dtlb_hit      = (state == ST_IDLE) & access & any_hit;
    assign bus.hit_idx       = bus.dtlb_hit ? low_idx : '0;
    assign bus.multi_hit     = bus.dtlb_hit & (hit_cnt > (IDX_W + 1)'(1));
    assign bus.ds_hold       = (state != ST_IDLE) | (access & ~any_hit);
    assign bus.utlb_req      = (state == ST_REQ);
    assign bus.utlb_req_ea   = req_ea_q;
    assign bus.ent_we        = fill_commit ? victim : '0;
    assign bus.ent_valid     = valid_q;
    assign bus.fill_rpn      = fill_rpn_q;
    assign bus.fill_size     = fill_size_q;
    assign bus.dtlb_miss_exc = exc_q;

endmodule

// File: tb/tb_p405s_dtlb_missctl.sv
// tb/tb_p405s_dtlb_missctl.sv - directed self-checking bench for the DTLB miss/fill controller
module tb_p405s_dtlb_missctl;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [3:0] we_seen;

    always #5 clk = ~clk;

    p405s_dtlb_missctl_if #(.NUM_ENT(4), .EA_W(22), .SIZE_W(7)) bus ();

    p405s_dtlb_missctl #(.NUM_ENT(4), .EA_W(22), .SIZE_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic fill(input logic [21:0] ea, input logic [21:0] rpn, output logic [3:0] we);
        bus.ds_req_valid = 1'b1;
        bus.msr_dr       = 1'b1;
        bus.exe_ds_ea    = ea;
        bus.ent_hit      = 4'b0000;
        step();
        bus.utlb_gnt = 1'b1;
        step();
        bus.utlb_gnt       = 1'b0;
        bus.utlb_rsp_valid = 1'b1;
        bus.utlb_hit       = 1'b1;
        bus.utlb_rpn       = rpn;
        bus.utlb_size      = 7'h01;
        step();
        bus.utlb_rsp_valid = 1'b0;
        bus.ds_req_valid   = 1'b0;
        #1;
        we = bus.ent_we;
        step();
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.ds_req_valid   = 1'b0;
        bus.msr_dr         = 1'b0;
        bus.exe_ds_ea      = '0;
        bus.ent_hit        = '0;
        bus.ds_flush       = 1'b0;
        bus.invalidate_all = 1'b0;
        bus.utlb_gnt       = 1'b0;
        bus.utlb_rsp_valid = 1'b0;
        bus.utlb_hit       = 1'b0;
        bus.utlb_rpn       = '0;
        bus.utlb_size      = '0;
        #1;
        chk("rst_hold", 32'(bus.ds_hold), 32'd0);
        chk("rst_req", 32'(bus.utlb_req), 32'd0);
        chk("rst_valid", 32'(bus.ent_valid), 32'd0);
        chk("rst_we", 32'(bus.ent_we), 32'd0);
        chk("rst_exc", 32'(bus.dtlb_miss_exc), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Miss and fill with a two-cycle grant wait
        bus.ds_req_valid = 1'b1;
        bus.msr_dr       = 1'b1;
        bus.exe_ds_ea    = 22'h0ABCDE;
        #1;
        chk("miss_hold_same_cycle", 32'(bus.ds_hold), 32'd1);
        chk("miss_no_hit", 32'(bus.dtlb_hit), 32'd0);
        step();
        bus.exe_ds_ea = 22'h111111;
        #1;
        chk("req_asserted", 32'(bus.utlb_req), 32'd1);
        chk("req_ea_c1", 32'(bus.utlb_req_ea), 32'h0ABCDE);
        step();
        #1;
        chk("req_held_c2", 32'(bus.utlb_req), 32'd1);
        chk("req_ea_c2", 32'(bus.utlb_req_ea), 32'h0ABCDE);
        step();
        bus.utlb_gnt = 1'b1;
        #1;
        chk("req_ea_gnt", 32'(bus.utlb_req_ea), 32'h0ABCDE);
        step();
        bus.utlb_gnt = 1'b0;
        #1;
        chk("wait_req_low", 32'(bus.utlb_req), 32'd0);
        chk("wait_hold", 32'(bus.ds_hold), 32'd1);
        bus.utlb_rsp_valid = 1'b1;
        bus.utlb_hit       = 1'b1;
        bus.utlb_rpn       = 22'h012345;
        bus.utlb_size      = 7'h03;
        step();
        bus.utlb_rsp_valid = 1'b0;
        bus.exe_ds_ea      = 22'h0ABCDE;
        #1;
        chk("fill_we", 32'(bus.ent_we), 32'h1);
        chk("fill_rpn", 32'(bus.fill_rpn), 32'h012345);
        chk("fill_size", 32'(bus.fill_size), 32'h03);
        chk("fill_hold", 32'(bus.ds_hold), 32'd1);
        step();
        bus.ent_hit = 4'b0001;
        #1;
        chk("post_fill_we", 32'(bus.ent_we), 32'h0);
        chk("post_fill_valid", 32'(bus.ent_valid), 32'h1);
        chk("replay_hit", 32'(bus.dtlb_hit), 32'd1);
        chk("replay_idx", 32'(bus.hit_idx), 32'd0);
        chk("replay_hold", 32'(bus.ds_hold), 32'd0);
        bus.ds_req_valid = 1'b0;
        bus.ent_hit      = 4'b0000;

        // Second fill lands in lowest invalid slot
        fill(22'h000222, 22'h000999, we_seen);
        chk("fill2_we", 32'(we_seen), 32'h2);
        chk("fill2_valid", 32'(bus.ent_valid), 32'h3);

        bus.ds_req_valid = 1'b1;
        bus.msr_dr       = 1'b1;
        bus.ent_hit      = 4'b0010;
        #1;
        chk("hit1", 32'(bus.dtlb_hit), 32'd1);
        chk("hit1_idx", 32'(bus.hit_idx), 32'd1);
        chk("hit1_hold", 32'(bus.ds_hold), 32'd0);
        chk("hit1_multi", 32'(bus.multi_hit), 32'd0);
        chk("hit1_req", 32'(bus.utlb_req), 32'd0);
        bus.ent_hit = 4'b0011;
        #1;
        chk("multi_idx", 32'(bus.hit_idx), 32'd0);
        chk("multi_flag", 32'(bus.multi_hit), 32'd1);
        bus.ent_hit = 4'b0100;
        #1;
        chk("invalid_ent_hit", 32'(bus.dtlb_hit), 32'd0);
        chk("invalid_ent_hold", 32'(bus.ds_hold), 32'd1);
        bus.msr_dr = 1'b0;
        #1;
        chk("dr_off_hold", 32'(bus.ds_hold), 32'd0);
        chk("dr_off_hit", 32'(bus.dtlb_hit), 32'd0);
        bus.msr_dr   = 1'b1;
        bus.ent_hit  = 4'b0000;
        bus.ds_flush = 1'b1;
        #1;
        chk("flush_idle_hold", 32'(bus.ds_hold), 32'd0);
        step();
        #1;
        chk("flush_idle_noreq", 32'(bus.utlb_req), 32'd0);
        bus.ds_flush     = 1'b0;
        bus.ds_req_valid = 1'b0;

        // UTLB miss raises a one-cycle exception
        bus.ds_req_valid = 1'b1;
        bus.exe_ds_ea    = 22'h00F00F;
        step();
        bus.utlb_gnt = 1'b1;
        step();
        bus.utlb_gnt       = 1'b0;
        bus.utlb_rsp_valid = 1'b1;
        bus.utlb_hit       = 1'b0;
        bus.ds_req_valid   = 1'b0;
        step();
        bus.utlb_rsp_valid = 1'b0;
        #1;
        chk("umiss_exc", 32'(bus.dtlb_miss_exc), 32'd1);
        chk("umiss_we", 32'(bus.ent_we), 32'd0);
        chk("umiss_hold", 32'(bus.ds_hold), 32'd0);
        step();
        #1;
        chk("umiss_exc_once", 32'(bus.dtlb_miss_exc), 32'd0);
        chk("umiss_valid", 32'(bus.ent_valid), 32'h3);

        // invalidateAll in WAIT squashes the later fill
        bus.ds_req_valid = 1'b1;
        bus.exe_ds_ea    = 22'h0C0C0C;
        step();
        bus.utlb_gnt = 1'b1;
        step();
        bus.utlb_gnt       = 1'b0;
        bus.invalidate_all = 1'b1;
        step();
        bus.invalidate_all = 1'b0;
        #1;
        chk("squash_valid_clr", 32'(bus.ent_valid), 32'h0);
        bus.utlb_rsp_valid = 1'b1;
        bus.utlb_hit       = 1'b1;
        bus.utlb_rpn       = 22'h3FFFFF;
        step();
        bus.utlb_rsp_valid = 1'b0;
        bus.ds_req_valid   = 1'b0;
        #1;
        chk("squash_we", 32'(bus.ent_we), 32'h0);
        chk("squash_exc", 32'(bus.dtlb_miss_exc), 32'd0);
        chk("squash_hold", 32'(bus.ds_hold), 32'd0);
        step();
        #1;
        chk("squash_exc_late", 32'(bus.dtlb_miss_exc), 32'd0);
        chk("squash_valid_stays", 32'(bus.ent_valid), 32'h0);

        // Round-robin replacement once all entries are valid
        for (int k = 0; k < 4; k++) fill(22'(k + 16), 22'(k), we_seen);
        chk("rr_full", 32'(bus.ent_valid), 32'hF);
        fill(22'h000100, 22'h1, we_seen);
        chk("rr_p0", 32'(we_seen), 32'h1);
        fill(22'h000101, 22'h2, we_seen);
        chk("rr_p1", 32'(we_seen), 32'h2);
        fill(22'h000102, 22'h3, we_seen);
        chk("rr_p2", 32'(we_seen), 32'h4);
        fill(22'h000103, 22'h4, we_seen);
        chk("rr_p3", 32'(we_seen), 32'h8);
        fill(22'h000104, 22'h5, we_seen);
        chk("rr_wrap", 32'(we_seen), 32'h1);

        // Asynchronous reset while waiting on the UTLB
        bus.ds_req_valid = 1'b1;
        bus.exe_ds_ea    = 22'h055555;
        step();
        bus.utlb_gnt = 1'b1;
        step();
        bus.utlb_gnt     = 1'b0;
        bus.ds_req_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(bus.utlb_req), 32'd0);
        chk("arst_hold", 32'(bus.ds_hold), 32'd0);
        chk("arst_valid", 32'(bus.ent_valid), 32'h0);
        chk("arst_rpn", 32'(bus.fill_rpn), 32'h0);
        chk("arst_ea", 32'(bus.utlb_req_ea), 32'h0);
        step();
        rst_n              = 1'b1;
        bus.utlb_rsp_valid = 1'b1;
        bus.utlb_hit       = 1'b1;
        step();
        bus.utlb_rsp_valid = 1'b0;
        #1;
        chk("arst_rsp_ignored_we", 32'(bus.ent_we), 32'h0);
        chk("arst_rsp_ignored_valid", 32'(bus.ent_valid), 32'h0);
        chk("arst_rsp_ignored_hold", 32'(bus.ds_hold), 32'd0);

        fill(22'h000A00, 22'h00AA0, we_seen);
        chk("post_rst_fill1", 32'(we_seen), 32'h1);
        fill(22'h000B00, 22'h00BB0, we_seen);
        chk("post_rst_fill2", 32'(we_seen), 32'h2);
        bus.ds_req_valid = 1'b1;
        bus.ent_hit      = 4'b0011;
        #1;
        chk("post_rst_hit", 32'(bus.dtlb_hit), 32'd1);
        chk("post_rst_idx", 32'(bus.hit_idx), 32'd0);
        chk("post_rst_multi", 32'(bus.multi_hit), 32'd1);
        bus.ds_req_valid = 1'b0;
        bus.ent_hit      = 4'b0000;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
